im_loader: RTL

IM_LOADER -- requirements
Module: im_loader

---
 rtl/im_loader_pkg.sv | 22 ++
 rtl/im_loader.sv | 114 +++++++++++
 2 files changed

// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader and its neighbours.
// Holds the loader state encoding, bus widths and the IM depth / base PC
// defaults (the fetch unit also takes its reset PC from BASE_PC_DEFAULT).
package im_loader_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned CNT_W    = 11;
  localparam int unsigned BCNT_W   = 2;

  localparam int unsigned IM_DEPTH_DEFAULT = 1024;
  localparam logic [WORD_W-1:0] BASE_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_e;

endpackage : im_loader_pkg

// File: rtl/im_loader.sv
// Instruction-memory loader: assembles a serial byte stream (MSB first) into
// 32-bit words and writes them into IM while holding the CPU fetch unit.
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   Start, Word_count begin a load of Word_count words (IDLE/DONE only)
//   Byte_in/_valid    serial program bytes; Byte_ready handshake back
//   Wr_en/addr/data   one-cycle IM write strobe per word
//   Wr_pc             PC of the word being written (combinational)
//   Cpu_hold, Done, Error  status levels
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned       IM_DEPTH = IM_DEPTH_DEFAULT,
  parameter logic [WORD_W-1:0] BASE_PC  = BASE_PC_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [CNT_W-1:0]  Word_count,
  input  logic [BYTE_W-1:0] Byte_in,
  input  logic              Byte_valid,
  output logic              Byte_ready,
  output logic              Wr_en,
  output logic [ADDR_W-1:0] Wr_addr,
  output logic [WORD_W-1:0] Wr_data,
  output logic [WORD_W-1:0] Wr_pc,
  output logic              Cpu_hold,
  output logic              Done,
  output logic              Error
);

  ld_state_e          state;
  logic [CNT_W-1:0]   count_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [BCNT_W-1:0]  byte_cnt_q;
  logic [23:0]        shift_q;    // first three bytes of the word in flight

  // PC of the word at Wr_addr
  assign Wr_pc = BASE_PC + WORD_W'({Wr_addr, 2'b00});

  // Loader FSM with inline byte assembler; all outputs registered
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      Byte_ready <= 1'b0;
      Wr_en      <= 1'b0;
      Wr_addr    <= '0;
      Wr_data    <= '0;
      Cpu_hold   <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            if (Word_count == '0) begin
              state <= ST_DONE;
              Done  <= 1'b1;
              Error <= 1'b0;
            end else if (WORD_W'(Word_count) > WORD_W'(IM_DEPTH)) begin
              // Oversized request: remain where we are and flag it
              Error <= 1'b1;
            end else begin
              state      <= ST_RECV;
              count_q    <= Word_count;
              idx_q      <= '0;
              byte_cnt_q <= '0;
              Error      <= 1'b0;
              Done       <= 1'b0;
              Cpu_hold   <= 1'b1;
              Byte_ready <= 1'b1;
            end
          end
        end

        ST_RECV: begin
          if (Byte_valid && Byte_ready) begin
            if (byte_cnt_q == BCNT_W'(3)) begin
              Wr_data    <= {shift_q, Byte_in};
              Wr_addr    <= idx_q;
              Wr_en      <= 1'b1;
              Byte_ready <= 1'b0;
              byte_cnt_q <= '0;
              state      <= ST_WRITE;
            end else begin
              shift_q    <= {shift_q[15:0], Byte_in};
              byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
            end
          end
        end

        ST_WRITE: begin
          Wr_en <= 1'b0;
          if ((CNT_W'(idx_q) + CNT_W'(1)) == count_q) begin
            state    <= ST_DONE;
            Done     <= 1'b1;
            Cpu_hold <= 1'b0;
          end else begin
            idx_q      <= idx_q + ADDR_W'(1);
            Byte_ready <= 1'b1;
            state      <= ST_RECV;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : im_loader
